// File: rtl/beep_scheduler.sv
// beep_scheduler: shares one speaker pin between NUM_REQ event sources.
// A rising edge on req[i] queues one beep for source i (one pending bit per
// source, index 0 has the highest priority). Each granted beep is a square
// wave of DUR_CYCLES clk cycles with the source's latched half-period,
// followed by GAP_CYCLES silent cycles before the next grant.
// Build macro: BEEP_PREEMPT_EN -- when defined, a pending request with a
// lower index than the playing source aborts the tone and is granted at once.
module beep_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int HP_W       = 16,
  parameter int DUR_CYCLES = 25000000,
  parameter int GAP_CYCLES = 2500000,
  parameter int IDW        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*HP_W-1:0] half_period,
  output logic                    speaker,
  output logic                    busy,
  output logic [IDW-1:0]          active_id,
  output logic                    done
);

  localparam int DUR_W = (DUR_CYCLES > 1) ? $clog2(DUR_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_t;

  state_t              state_q,     state_d;
  logic [NUM_REQ-1:0]  req_q,       req_d;
  logic [NUM_REQ-1:0]  pending_q,   pending_d;
  logic [IDW-1:0]      active_id_q, active_id_d;
  logic [HP_W-1:0]     hp_q,        hp_d;
  logic [HP_W-1:0]     tone_cnt_q,  tone_cnt_d;
  logic [DUR_W-1:0]    dur_q,       dur_d;
  logic [GAP_W-1:0]    gap_q,       gap_d;
  logic                speaker_q,   speaker_d;
  logic                done_q,      done_d;

  logic [NUM_REQ-1:0]  rise;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [IDW-1:0]      grant_idx;
  logic [HP_W-1:0]     grant_hp;
  logic                preempt;
  logic                do_grant;

  // Arbitration: isolate the lowest pending source, its index and its tone period.
  always_comb begin
    grant_onehot = pending_q & (~pending_q + NUM_REQ'(1));
    grant_idx    = '0;
    grant_hp     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) begin
        grant_idx = IDW'(i);
        grant_hp  = half_period[i*HP_W +: HP_W];
      end
    end
    // A zero half-period would never toggle; play it as the fastest tone instead.
    if (grant_hp == '0) grant_hp = HP_W'(1);
  end

  // Preemption request: only a lower index than the playing source may abort it.
  always_comb begin
    preempt = 1'b0;
`ifdef BEEP_PREEMPT_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pending_q[i] && (IDW'(i) < active_id_q) && (state_q == ST_PLAY)) preempt = 1'b1;
    end
`endif
  end

  // Next-state and datapath: IDLE grants, PLAY shapes the tone, GAP enforces silence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latches).
    state_d     = state_q;
    req_d       = req;
    active_id_d = active_id_q;
    hp_d        = hp_q;
    tone_cnt_d  = tone_cnt_q;
    dur_d       = dur_q;
    gap_d       = gap_q;
    speaker_d   = speaker_q;
    done_d      = 1'b0;
    do_grant    = 1'b0;
    rise        = req & ~req_q;

    case (state_q)
      ST_IDLE: begin
        do_grant = |pending_q;
      end
      ST_PLAY: begin
        if (preempt) begin
          do_grant = 1'b1;
        end else if (dur_q == '0) begin
          speaker_d = 1'b0;
          done_d    = 1'b1;
          gap_d     = GAP_LAST;
          state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          dur_d = dur_q - DUR_W'(1);
          if (tone_cnt_q == hp_q - HP_W'(1)) begin
            speaker_d  = ~speaker_q;
            tone_cnt_d = '0;
          end else begin
            tone_cnt_d = tone_cnt_q + HP_W'(1);
          end
        end
      end
      ST_GAP: begin
        speaker_d = 1'b0;
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_grant) begin
      active_id_d = grant_idx;
      hp_d        = grant_hp;
      dur_d       = DUR_LAST;
      tone_cnt_d  = '0;
      speaker_d   = 1'b0;
      state_d     = ST_PLAY;
    end

    // A fresh edge on the source being granted wins over the grant's clear.
    pending_d = (pending_q & ~(do_grant ? grant_onehot : '0)) | rise;
  end

  // State register; reset silences the speaker immediately and drops all requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      pending_q   <= '0;
      active_id_q <= '0;
      hp_q        <= '0;
      tone_cnt_q  <= '0;
      dur_q       <= '0;
      gap_q       <= '0;
      speaker_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      req_q       <= req_d;
      pending_q   <= pending_d;
      active_id_q <= active_id_d;
      hp_q        <= hp_d;
      tone_cnt_q  <= tone_cnt_d;
      dur_q       <= dur_d;
      gap_q       <= gap_d;
      speaker_q   <= speaker_d;
      done_q      <= done_d;
    end
  end

  assign speaker   = speaker_q;
  assign busy      = (state_q != ST_IDLE);
  assign active_id = active_id_q;
  assign done      = done_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// Testbench for beep_scheduler (DUR_CYCLES=20, GAP_CYCLES=4, HP_W=16).
// A reference model tracks each beep as "cycles elapsed since grant" and
// derives speaker/busy/done from that elapsed time; a negedge monitor
// compares it with the DUT every cycle, and scenario tasks add targeted checks.
`timescale 1ns/1ps
module tb_beep_scheduler;

  localparam int NUM_REQ = 4;
  localparam int HP_W    = 16;
  localparam int DUR     = 20;
  localparam int GAP     = 4;
  localparam int IDW     = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [NUM_REQ-1:0]      req = '0;
  logic [NUM_REQ*HP_W-1:0] half_period = '0;
  logic                    speaker;
  logic                    busy;
  logic [IDW-1:0]          active_id;
  logic                    done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  beep_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .HP_W       (HP_W),
    .DUR_CYCLES (DUR),
    .GAP_CYCLES (GAP),
    .IDW        (IDW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .half_period (half_period),
    .speaker     (speaker),
    .busy        (busy),
    .active_id   (active_id),
    .done        (done)
  );

  // ---------------- reference model ----------------
  bit                 m_active  = 0;
  int                 m_t       = 0;   // cycles elapsed since the grant edge
  int                 m_hp      = 1;
  int                 m_g;
  logic [IDW-1:0]     m_id      = '0;
  logic [NUM_REQ-1:0] m_pend    = '0;
  logic [NUM_REQ-1:0] m_reqprev = '0;
  logic [NUM_REQ-1:0] m_rise, m_clr;
  bit                 m_grant;
  bit                 e_spk = 0, e_busy = 0, e_done = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_t = 0; m_id = '0; m_pend = '0; m_reqprev = '0;
      e_spk = 0; e_busy = 0; e_done = 0;
    end else begin
      m_rise  = req & ~m_reqprev;
      m_clr   = '0;
      m_grant = 0;
      e_done  = 0;
      if (!m_active) begin
        m_grant = (m_pend != 0);
      end else begin
`ifdef BEEP_PREEMPT_EN
        if (m_t < DUR && (int'(m_pend) & ((1 << int'(m_id)) - 1)) != 0) m_grant = 1;
`endif
        if (!m_grant) begin
          m_t = m_t + 1;
          if (m_t == DUR) e_done = 1;
          if (m_t >= DUR + GAP) m_active = 0;
        end
      end
      if (m_grant) begin
        m_g = 0;
        while (!m_pend[m_g]) m_g++;
        m_clr[m_g] = 1'b1;
        m_id       = IDW'(m_g);
        m_hp       = int'(half_period[m_g*HP_W +: HP_W]);
        if (m_hp == 0) m_hp = 1;
        m_t        = 0;
        m_active   = 1;
      end
      m_pend    = (m_pend & ~m_clr) | m_rise;
      m_reqprev = req;
      e_busy    = m_active;
      e_spk     = m_active && (m_t < DUR) && (((m_t / m_hp) % 2) == 1);
    end
  end

  // Cycle-by-cycle scoreboard against the model.
  always @(negedge clk) begin
    tests_run++;
    if ({speaker, busy, done, active_id} !== {e_spk, e_busy, e_done, m_id}) begin
      tests_failed++;
      $display("FAIL model_cmp t=%0t spk/busy/done/id got %b/%b/%b/%0d expected %b/%b/%b/%0d",
               $time, speaker, busy, done, active_id, e_spk, e_busy, e_done, m_id);
    end
  end

  task automatic set_hp(input int idx, input int val);
    half_period[idx*HP_W +: HP_W] = HP_W'(val);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    for (int i = 0; i < NUM_REQ; i++) set_hp(i, 3);
    #1 rst = 1'b1;
    cycles(3);
    tests_run++;
    if ({speaker, busy, done, active_id} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_values got %b expected 00000", {speaker, busy, done, active_id});
    end
    rst = 1'b0;
    cycles(3);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset busy got %b expected 0", busy);
    end
  endtask

  task automatic test_single_beep;
    int toggles = 0, dones = 0, done_k = -1, low_k = -1, first_hi = -1;
    logic prev;
    req[2] = 1'b1;
    cycles(1);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_latency_e0 busy got %b expected 0", busy);
    end
    cycles(1);
    tests_run++;
    if (busy !== 1'b1 || active_id !== 2'd2) begin
      tests_failed++; $display("FAIL single_grant busy/id got %b/%0d expected 1/2", busy, active_id);
    end
    prev = speaker;
    for (int k = 1; k <= 40; k++) begin
      cycles(1);
      if (speaker !== prev) toggles++;
      if (speaker === 1'b1 && first_hi < 0) first_hi = k;
      prev = speaker;
      if (done === 1'b1) begin dones++; done_k = k; end
      if (busy === 1'b0 && low_k < 0) low_k = k;
    end
    tests_run++;
    if (toggles != 6 || dones != 1 || first_hi != 3) begin
      tests_failed++;
      $display("FAIL single_tone toggles/dones/first_high got %0d/%0d/%0d expected 6/1/3", toggles, dones, first_hi);
    end
    tests_run++;
    if (low_k - done_k != GAP) begin
      tests_failed++;
      $display("FAIL single_gap busy_low-done got %0d expected %0d", low_k - done_k, GAP);
    end
    req[2] = 1'b0;
    cycles(5);
  endtask

  task automatic test_simultaneous;
    int ids[$];
    req[3] = 1'b1; req[1] = 1'b1;
    for (int k = 0; k < 120; k++) begin
      cycles(1);
      if (done === 1'b1) ids.push_back(int'(active_id));
    end
    tests_run++;
    if (ids.size() != 2 || ids[0] != 1 || ids[1] != 3) begin
      tests_failed++;
      $display("FAIL simultaneous_order done count got %0d (first ids %0d,%0d) expected 2 (1,3)",
               ids.size(), (ids.size() > 0) ? ids[0] : -1, (ids.size() > 1) ? ids[1] : -1);
    end
    req = '0;
    cycles(5);
  endtask

  task automatic test_hold;
    int dones = 0;
    req[0] = 1'b1;
    for (int k = 0; k < 100; k++) begin cycles(1); if (done === 1'b1) dones++; end
    tests_run++;
    if (dones != 1) begin
      tests_failed++; $display("FAIL hold_single_beep dones got %0d expected 1", dones);
    end
    req[0] = 1'b0;
    cycles(2);
    req[0] = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin cycles(1); if (done === 1'b1) dones++; end
    tests_run++;
    if (dones != 1) begin
      tests_failed++; $display("FAIL hold_second_beep dones got %0d expected 1", dones);
    end
    req[0] = 1'b0;
    cycles(10);
  endtask

  task automatic test_late_high_prio;
    int ids[$];
    req[2] = 1'b1;
    cycles(2);   // now at PLAY cycle 0 of source 2
    cycles(5);   // PLAY cycle 5
    req[0] = 1'b1;
    cycles(1);
    req[0] = 1'b0;
    cycles(1);
`ifdef BEEP_PREEMPT_EN
    tests_run++;
    if (active_id !== 2'd0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL preempt_regrant busy/id got %b/%0d expected 1/0", busy, active_id);
    end
`else
    tests_run++;
    if (active_id !== 2'd2 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL no_preempt_hold busy/id got %b/%0d expected 1/2", busy, active_id);
    end
`endif
    for (int k = 0; k < 80; k++) begin
      cycles(1);
      if (done === 1'b1) ids.push_back(int'(active_id));
    end
`ifdef BEEP_PREEMPT_EN
    tests_run++;
    if (ids.size() != 1 || ids[0] != 0) begin
      tests_failed++;
      $display("FAIL preempt_dones count got %0d expected 1 (id 0)", ids.size());
    end
`else
    tests_run++;
    if (ids.size() != 2 || ids[0] != 2 || ids[1] != 0) begin
      tests_failed++;
      $display("FAIL no_preempt_order done count got %0d (first ids %0d,%0d) expected 2 (2,0)",
               ids.size(), (ids.size() > 0) ? ids[0] : -1, (ids.size() > 1) ? ids[1] : -1);
    end
`endif
    req = '0;
    cycles(5);
  endtask

  task automatic test_hp_zero;
    int toggles = 0;
    logic prev;
    set_hp(1, 0);
    req[1] = 1'b1;
    cycles(2);
    prev = speaker;
    for (int k = 1; k <= 30; k++) begin
      cycles(1);
      if (k == 8) set_hp(1, 7);
      if (speaker !== prev) toggles++;
      prev = speaker;
    end
    tests_run++;
    if (toggles != DUR) begin
      tests_failed++; $display("FAIL hp_zero_toggles got %0d expected %0d", toggles, DUR);
    end
    req[1] = 1'b0;
    set_hp(1, 3);
    cycles(5);
  endtask

  task automatic test_reset_mid;
    int busy_cnt = 0;
    req[2] = 1'b1;
    cycles(2);
    cycles(5);
    req[3] = 1'b1;
    cycles(5);   // PLAY cycle 10, speaker is high here with hp=3
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({speaker, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_mid_async spk/busy/done got %b expected 000", {speaker, busy, done});
    end
    req = '0;
    cycles(1);
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin cycles(1); if (busy === 1'b1) busy_cnt++; end
    tests_run++;
    if (busy_cnt != 0) begin
      tests_failed++; $display("FAIL reset_mid_pending_lost busy cycles got %0d expected 0", busy_cnt);
    end
  endtask

  task automatic test_random;
    int dones = 0;
    for (int k = 0; k < 1500; k++) begin
      cycles(1);
      if ($urandom_range(0, 15) == 0) req[$urandom_range(0, NUM_REQ-1)] ^= 1'b1;
      if ($urandom_range(0, 31) == 0) set_hp($urandom_range(0, NUM_REQ-1), $urandom_range(0, 4));
      if (done === 1'b1) dones++;
    end
    req = '0;
    cycles(60);
    tests_run++;
    if (dones == 0) begin
      tests_failed++; $display("FAIL random_activity dones got 0 expected nonzero");
    end
  endtask

  initial begin
    test_reset();
    test_single_beep();
    test_simultaneous();
    test_hold();
    test_late_high_prio();
    test_hp_zero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
